// File: rtl/riscv_pipe_pkg.sv
// Shared constants and helpers for the writeback arbiter.
package riscv_pipe_pkg;

  // Default payload width of a writeback producer.
  localparam int unsigned DATA_W = 32;

  // Output slot state: IDLE means empty, FULL means mem_wb_rdy is asserted.
  typedef enum logic {
    WB_ARB_IDLE = 1'b0,
    WB_ARB_FULL = 1'b1
  } wb_arb_state_e;

  // Ceiling log2 with a floor of 1, so a 1-bit index is used even for tiny vectors.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/riscv_rr_pick.sv
// Combinational round-robin picker: keeps the last grant while hold_en_i allows,
// otherwise searches upward from last_grant_i + 1 with wrap-around.
module riscv_rr_pick #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned SRC_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [SRC_W-1:0] last_grant_i,
  input  logic             hold_en_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [SRC_W-1:0] grant_idx_o
);

  int unsigned      sum;
  logic [SRC_W-1:0] cand;
  logic             found;

  // Pick one requester; the search visits last_grant_i itself last so a lone requester
  // is still served after its burst expires.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    sum         = 0;
    cand        = '0;
    found       = 1'b0;
    if (hold_en_i && req_i[last_grant_i]) begin
      grant_o[last_grant_i] = 1'b1;
      grant_idx_o           = last_grant_i;
    end else begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        sum = 32'(last_grant_i) + k;
        if (sum >= NREQ) begin
          sum = sum - NREQ;
        end
        cand = SRC_W'(sum);
        if (!found && req_i[cand]) begin
          found         = 1'b1;
          grant_o[cand] = 1'b1;
          grant_idx_o   = cand;
        end
      end
    end
  end

endmodule

// File: rtl/riscv_wb_arb.sv
// Round-robin writeback arbiter with a single registered output slot and bounded bursts.
// Optional macro RISCV_WB_ARB_PRIO_EN: requester 0 always wins when it is ready.
module riscv_wb_arb #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned DATA_W    = riscv_pipe_pkg::DATA_W,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned SRC_W     = riscv_pipe_pkg::clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_rdy,
  output logic [NREQ-1:0]          req_ack,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic                     mem_wb_rdy,
  input  logic                     mem_wb_ack,
  output logic [DATA_W-1:0]        mem_wb_data,
  output logic [SRC_W-1:0]         mem_wb_src
);

  import riscv_pipe_pkg::*;

  localparam int unsigned BW = clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MaxBurstW = BW'(MAX_BURST);

  wb_arb_state_e     state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [SRC_W-1:0]  last_q, last_d;
  logic [BW-1:0]     burst_q, burst_d;

  logic              load;
  logic              hold_en;
  logic              any_ack;
  logic [NREQ-1:0]   rr_grant;
  logic [SRC_W-1:0]  rr_idx;
  logic [NREQ-1:0]   pick_oh;
  logic [SRC_W-1:0]  pick_idx;

  assign hold_en = (burst_q < MaxBurstW);

  riscv_rr_pick #(
    .NREQ  (NREQ),
    .SRC_W (SRC_W)
  ) u_pick (
    .req_i        (req_rdy),
    .last_grant_i (last_q),
    .hold_en_i    (hold_en),
    .grant_o      (rr_grant),
    .grant_idx_o  (rr_idx)
  );

  // Final pick and acknowledge; acks are suppressed while reset is asserted.
  always_comb begin
    load = (state_q == WB_ARB_IDLE) || mem_wb_ack;
`ifdef RISCV_WB_ARB_PRIO_EN
    if (req_rdy[0]) begin
      pick_oh  = NREQ'(1);
      pick_idx = '0;
    end else begin
      pick_oh  = rr_grant;
      pick_idx = rr_idx;
    end
`else
    pick_oh  = rr_grant;
    pick_idx = rr_idx;
`endif
    req_ack = (load && !rst) ? pick_oh : '0;
    any_ack = |req_ack;
  end

  // Next-state for slot, source, rotation pointer and burst counter.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    last_d  = last_q;
    burst_d = burst_q;
    if (any_ack) begin
      state_d = WB_ARB_FULL;
      src_d   = pick_idx;
      for (int unsigned g = 0; g < NREQ; g++) begin
        if (req_ack[g]) begin
          data_d = req_data[g*DATA_W +: DATA_W];
        end
      end
      if (pick_idx == last_q) begin
        // Saturate so a lone requester never wraps back into a fresh burst.
        if (burst_q != MaxBurstW) begin
          burst_d = burst_q + 1'b1;
        end
      end else begin
        burst_d = BW'(1);
        last_d  = pick_idx;
      end
    end else if (load) begin
      state_d = WB_ARB_IDLE;
      burst_d = '0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WB_ARB_IDLE;
      data_q  <= '0;
      src_q   <= '0;
      last_q  <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  assign mem_wb_rdy  = (state_q == WB_ARB_FULL);
  assign mem_wb_data = data_q;
  assign mem_wb_src  = src_q;

endmodule

// File: tb/tb_riscv_wb_arb.sv
// Bench for riscv_wb_arb: a 2-requester/burst-4 instance and a 3-requester/burst-1
// instance driven side by side and checked against a behavioural arbitration model.
module tb_riscv_wb_arb;

  localparam int unsigned DW = 32;
`ifdef RISCV_WB_ARB_PRIO_EN
  localparam bit Prio = 1'b1;
`else
  localparam bit Prio = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]      a_rdy, a_ack;
  logic [2*DW-1:0] a_data;
  logic            a_wb_rdy, a_wb_ack;
  logic [DW-1:0]   a_wb_data;
  logic [0:0]      a_wb_src;

  logic [2:0]      b_rdy, b_ack;
  logic [3*DW-1:0] b_data;
  logic            b_wb_rdy, b_wb_ack;
  logic [DW-1:0]   b_wb_data;
  logic [1:0]      b_wb_src;

  always #5 clk = ~clk;

  riscv_wb_arb #(.NREQ(2), .DATA_W(DW), .MAX_BURST(4), .SRC_W(1)) dut_a (
    .clk (clk), .rst (rst), .req_rdy (a_rdy), .req_ack (a_ack), .req_data (a_data),
    .mem_wb_rdy (a_wb_rdy), .mem_wb_ack (a_wb_ack), .mem_wb_data (a_wb_data),
    .mem_wb_src (a_wb_src)
  );

  riscv_wb_arb #(.NREQ(3), .DATA_W(DW), .MAX_BURST(1), .SRC_W(2)) dut_b (
    .clk (clk), .rst (rst), .req_rdy (b_rdy), .req_ack (b_ack), .req_data (b_data),
    .mem_wb_rdy (b_wb_rdy), .mem_wb_ack (b_wb_ack), .mem_wb_data (b_wb_data),
    .mem_wb_src (b_wb_src)
  );

  int checks = 0;
  int errors = 0;

  // Model state per instance (0 = dut_a, 1 = dut_b).
  int            m_lg[2];
  int            m_burst[2];
  bit            m_valid[2];
  logic [DW-1:0] m_data[2];
  int            m_src[2];
  int            e_pick[2];
  logic [2:0]    o_ack[2];

  function automatic int ref_pick(input int nreq, input int mb, input logic [2:0] rdy,
                                  input int lg, input int burst);
    int idx;
    if (Prio && rdy[0]) return 0;
    idx = lg;
    if (rdy[idx[1:0]] && burst < mb) return lg;
    for (int k = 1; k <= nreq; k++) begin
      idx = (lg + k) % nreq;
      if (rdy[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [2:0] onehot(input int p);
    logic [2:0] v;
    v = 3'b001;
    return (p < 0) ? 3'b000 : (v << p);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lg[i] = 0; m_burst[i] = 0; m_valid[i] = 0; m_data[i] = '0; m_src[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic [2:0] rdy, input bit wack,
                            input logic [3*DW-1:0] data);
    int nreq, mb, p;
    bit load;
    nreq = (i == 0) ? 2 : 3;
    mb   = (i == 0) ? 4 : 1;
    load = !m_valid[i] || wack;
    p    = load ? ref_pick(nreq, mb, rdy, m_lg[i], m_burst[i]) : -1;
    e_pick[i] = p;
    if (p >= 0) begin
      if (p == m_lg[i]) m_burst[i] = (m_burst[i] < mb) ? m_burst[i] + 1 : mb;
      else m_burst[i] = 1;
      m_lg[i] = p; m_valid[i] = 1; m_data[i] = data[p*DW +: DW]; m_src[i] = p;
    end else if (load) begin
      m_valid[i] = 0; m_burst[i] = 0;
    end
  endtask

  // One clock: drive, sample combinational acks, advance model, step past the edge.
  task automatic cycle(input logic [2:0] ra, input bit wa, input logic [2:0] rb,
                       input bit wb, input bit rnd);
    if (rnd) begin
      a_data = {$urandom, $urandom};
      b_data = {$urandom, $urandom, $urandom};
    end
    a_rdy = ra[1:0]; a_wb_ack = wa; b_rdy = rb; b_wb_ack = wb;
    #2;
    o_ack[0] = {1'b0, a_ack};
    o_ack[1] = b_ack;
    model_step(0, ra & 3'b011, wa, {32'd0, a_data});
    model_step(1, rb, wb, b_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rdy = 2'b11; b_rdy = 3'b111; a_wb_ack = 0; b_wb_ack = 0;
    a_data = {$urandom, $urandom}; b_data = {$urandom, $urandom, $urandom};
    #12;
    checks++;
    if ({a_ack, b_ack} !== 5'b0) begin
      errors++; $display("FAIL reset_ack got %b want 0", {a_ack, b_ack});
    end
    checks++;
    if ({a_wb_rdy, a_wb_data, a_wb_src} !== '0) begin
      errors++; $display("FAIL reset_a got rdy=%b data=%h src=%h want 0", a_wb_rdy, a_wb_data,
                         a_wb_src);
    end
    checks++;
    if ({b_wb_rdy, b_wb_data, b_wb_src} !== '0) begin
      errors++; $display("FAIL reset_b got rdy=%b data=%h src=%h want 0", b_wb_rdy, b_wb_data,
                         b_wb_src);
    end
    model_reset();
    rst = 0;
  endtask

  task automatic test_back_to_back();
    int exp_src;
    logic [DW-1:0] exp_d;
    for (int n = 0; n < 12; n++) begin
      a_data = {32'(32'hB000_0000 + n), 32'(32'hA000_0000 + n)};
      cycle(3'b011, 1'b1, 3'b000, 1'b1, 1'b0);
      exp_src = Prio ? 0 : (n / 4) % 2;
      exp_d   = (exp_src == 0) ? 32'(32'hA000_0000 + n) : 32'(32'hB000_0000 + n);
      checks++;
      if (o_ack[0] !== onehot(exp_src)) begin
        errors++; $display("FAIL b2b_ack n=%0d got %b want %b", n, o_ack[0], onehot(exp_src));
      end
      checks++;
      if (a_wb_rdy !== 1'b1 || a_wb_src !== 1'(exp_src) || a_wb_data !== exp_d) begin
        errors++; $display("FAIL b2b_slot n=%0d got rdy=%b src=%0d data=%h want 1/%0d/%h", n,
                           a_wb_rdy, a_wb_src, a_wb_data, exp_src, exp_d);
      end
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] held_d;
    logic          held_s;
    cycle(3'b011, 1'b1, 3'b000, 1'b1, 1'b1);
    held_d = m_data[0];
    held_s = m_src[0][0];
    checks++;
    if (a_wb_rdy !== 1'b1 || a_wb_data !== held_d) begin
      errors++; $display("FAIL stall_fill got rdy=%b data=%h want 1/%h", a_wb_rdy, a_wb_data,
                         held_d);
    end
    for (int n = 0; n < 3; n++) begin
      cycle(3'b011, 1'b0, 3'b000, 1'b1, 1'b1);
      checks++;
      if (o_ack[0] !== 3'b000 || a_wb_rdy !== 1'b1 || a_wb_data !== held_d ||
          a_wb_src !== held_s) begin
        errors++; $display("FAIL stall_hold n=%0d got ack=%b rdy=%b data=%h src=%b want 0/1/%h/%b",
                           n, o_ack[0], a_wb_rdy, a_wb_data, a_wb_src, held_d, held_s);
      end
    end
    cycle(3'b011, 1'b1, 3'b000, 1'b1, 1'b1);
    checks++;
    if (o_ack[0] === 3'b000 || o_ack[0] !== onehot(e_pick[0])) begin
      errors++; $display("FAIL stall_release_ack got %b want %b", o_ack[0], onehot(e_pick[0]));
    end
    checks++;
    if (a_wb_rdy !== 1'b1 || a_wb_data !== m_data[0] || a_wb_src !== m_src[0][0]) begin
      errors++; $display("FAIL stall_release_slot got data=%h src=%b want %h/%0d", a_wb_data,
                         a_wb_src, m_data[0], m_src[0]);
    end
  endtask

  task automatic test_single_req();
    for (int n = 0; n < 6; n++) begin
      cycle(3'b010, 1'b1, 3'b000, 1'b1, 1'b1);
      checks++;
      if (o_ack[0] !== 3'b010 || a_wb_rdy !== 1'b1 || a_wb_src !== 1'b1 ||
          a_wb_data !== a_data[63:32]) begin
        errors++; $display("FAIL single_req n=%0d got ack=%b rdy=%b src=%b data=%h want 010/1/1/%h",
                           n, o_ack[0], a_wb_rdy, a_wb_src, a_wb_data, a_data[63:32]);
      end
    end
  endtask

  task automatic test_async_reset();
    a_data[31:0] = 32'hDEAD_BEEF;
    cycle(3'b001, 1'b1, 3'b001, 1'b1, 1'b0);
    checks++;
    if (a_wb_rdy !== 1'b1 || a_wb_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL arst_setup got rdy=%b data=%h want 1/deadbeef", a_wb_rdy, a_wb_data);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({a_wb_rdy, a_wb_data, a_wb_src, a_ack, b_wb_rdy, b_wb_data, b_wb_src, b_ack} !== '0) begin
      errors++; $display("FAIL arst_clear got a=%b/%h/%b ack=%b b=%b/%h/%b ack=%b want 0", a_wb_rdy,
                         a_wb_data, a_wb_src, a_ack, b_wb_rdy, b_wb_data, b_wb_src, b_ack);
    end
    model_reset();
    #1 rst = 0;
    cycle(3'b011, 1'b1, 3'b110, 1'b1, 1'b1);
    checks++;
    if (o_ack[0] !== 3'b001 || o_ack[1] !== 3'b010) begin
      errors++; $display("FAIL arst_first_grant got a=%b b=%b want 001/010", o_ack[0], o_ack[1]);
    end
  endtask

  task automatic test_burst_prio();
    int exp;
    for (int n = 0; n < 2; n++) begin
      cycle(3'b010, 1'b1, 3'b000, 1'b1, 1'b1);
      checks++;
      if (o_ack[0] !== 3'b010) begin
        errors++; $display("FAIL prio_setup n=%0d got %b want 010", n, o_ack[0]);
      end
    end
    for (int n = 0; n < 4; n++) begin
      cycle(3'b011, 1'b1, 3'b000, 1'b1, 1'b1);
      exp = Prio ? 0 : ((n < 2) ? 1 : 0);
      checks++;
      if (o_ack[0] !== onehot(exp) || a_wb_src !== 1'(exp)) begin
        errors++; $display("FAIL prio_burst n=%0d got ack=%b src=%b want %b/%0d", n, o_ack[0],
                           a_wb_src, onehot(exp), exp);
      end
    end
  endtask

  task automatic test_nreq3();
    int   exp3[4] = '{0, 2, 0, 2};
    int   exp;
    bit   got1;
    #2 rst = 1;
    #2 model_reset();
    rst = 0;
    for (int n = 0; n < 4; n++) begin
      cycle(3'b000, 1'b1, 3'b101, 1'b1, 1'b1);
      exp = Prio ? 0 : exp3[n];
      checks++;
      if (o_ack[1] !== onehot(exp) || b_wb_src !== 2'(exp) || b_wb_data !== m_data[1]) begin
        errors++; $display("FAIL rr3 n=%0d got ack=%b src=%0d data=%h want %b/%0d/%h", n, o_ack[1],
                           b_wb_src, b_wb_data, onehot(exp), exp, m_data[1]);
      end
    end
    got1 = 0;
    for (int n = 0; n < 2; n++) begin
      cycle(3'b000, 1'b1, Prio ? 3'b110 : 3'b111, 1'b1, 1'b1);
      if (o_ack[1] === 3'b010) got1 = 1;
    end
    checks++;
    if (!got1) begin
      errors++; $display("FAIL rr3_late_req got no grant to req 1 within 2 transfers want grant");
    end
  endtask

  task automatic test_random();
    logic [2:0] ra, rb;
    bit         wa, wb;
    for (int n = 0; n < 300; n++) begin
      ra = 3'($urandom_range(3, 0));
      rb = 3'($urandom_range(7, 0));
      wa = ($urandom_range(3, 0) != 0);
      wb = ($urandom_range(3, 0) != 0);
      cycle(ra, wa, rb, wb, 1'b1);
      checks++;
      if (o_ack[0] !== onehot(e_pick[0]) || o_ack[1] !== onehot(e_pick[1])) begin
        errors++; $display("FAIL rand_ack n=%0d got a=%b b=%b want a=%b b=%b", n, o_ack[0],
                           o_ack[1], onehot(e_pick[0]), onehot(e_pick[1]));
      end
      checks++;
      if (a_wb_rdy !== m_valid[0] || a_wb_data !== m_data[0] || a_wb_src !== m_src[0][0] ||
          b_wb_rdy !== m_valid[1] || b_wb_data !== m_data[1] || b_wb_src !== m_src[1][1:0]) begin
        errors++; $display("FAIL rand_slot n=%0d got a=%b/%h/%0d b=%b/%h/%0d want a=%b/%h/%0d b=%b/%h/%0d",
                           n, a_wb_rdy, a_wb_data, a_wb_src, b_wb_rdy, b_wb_data, b_wb_src,
                           m_valid[0], m_data[0], m_src[0], m_valid[1], m_data[1], m_src[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_single_req();
    test_async_reset();
    test_burst_prio();
    test_nreq3();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
